// File: rtl/vedic_pkg.sv
// Shared types and helpers for the Vedic multiplier hierarchy.
// The operand and product widths are fixed by the leaf 4x4 block.
package vedic_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef logic [OP_W-1:0]   op4_t;
   typedef logic [PROD_W-1:0] prod8_t;

   // Half adder: returns {carry, sum}.
   function automatic logic [1:0] half_add(input logic i_x, input logic i_y);
      return {i_x & i_y, i_x ^ i_y};
   endfunction

   // Full adder: returns {carry, sum}.
   function automatic logic [1:0] full_add(input logic i_x, input logic i_y, input logic i_c);
      return {(i_x & i_y) | (i_x & i_c) | (i_y & i_c), i_x ^ i_y ^ i_c};
   endfunction

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder built from full-adder slices.
module adder_4bit
   import vedic_pkg::*;
(
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);

   logic [4:0] w_carry;

   assign w_carry[0] = i_cin;

   for (genvar g = 0; g < 4; g++) begin : g_slice
      assign {w_carry[g+1], o_sum[g]} = full_add(i_a[g], i_b[g], w_carry[g]);
   end

   assign o_cout = w_carry[4];

endmodule

// File: rtl/mult_2bit.sv
// 2x2 Vedic multiplier cell: one AND for bit 0, then two half adders
// combine the vertical and crosswise partial products.
module mult_2bit
   import vedic_pkg::*;
(
   input  logic [1:0] i_a,
   input  logic [1:0] i_b,
   output logic [3:0] o_p
);

   logic w_p0;
   logic w_p1;
   logic w_c1;
   logic w_p2;
   logic w_p3;

   assign w_p0          = i_a[0] & i_b[0];
   // Crosswise terms a1*b0 and a0*b1 form bit 1 and a carry.
   assign {w_c1, w_p1}  = half_add(i_a[1] & i_b[0], i_a[0] & i_b[1]);
   // Vertical high term a1*b1 absorbs the carry; its carry is bit 3.
   assign {w_p3, w_p2}  = half_add(i_a[1] & i_b[1], w_c1);

   assign o_p = {w_p3, w_p2, w_p1, w_p0};

endmodule

// File: rtl/mult_4bit.sv
// Unsigned 4x4 Vedic multiplier with a registered 8-bit product.
// No handshake: A/B are sampled on every rising edge while rst is low and
// Result presents their product after that edge; one product per cycle.
// rst clears Result asynchronously and discards any in-flight product.
module mult_4bit
   import vedic_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [7:0] Result
);

   logic [3:0] w_q0;     // Al*Bl
   logic [3:0] w_q1;     // Ah*Bl
   logic [3:0] w_q2;     // Al*Bh
   logic [3:0] w_q3;     // Ah*Bh
   logic [3:0] w_t1_lo;
   logic       w_t1_c;   // bit 4 of t1 = q1 + q2
   logic [3:0] w_t2_lo;
   logic       w_t2_c;   // carry out of the low nibble of t2
   logic       w_t2_b4;
   logic       w_t2_c5;
   logic       w_t2_b5;
   logic [7:0] w_product;
   prod8_t     r_result;

   mult_2bit u_m0 (.i_a(A[1:0]), .i_b(B[1:0]), .o_p(w_q0));
   mult_2bit u_m1 (.i_a(A[3:2]), .i_b(B[1:0]), .o_p(w_q1));
   mult_2bit u_m2 (.i_a(A[1:0]), .i_b(B[3:2]), .o_p(w_q2));
   mult_2bit u_m3 (.i_a(A[3:2]), .i_b(B[3:2]), .o_p(w_q3));

   // Middle column: the two crosswise products, weight 4.
   adder_4bit u_add_t1 (
      .i_a   (w_q1),
      .i_b   (w_q2),
      .i_cin (1'b0),
      .o_sum (w_t1_lo),
      .o_cout(w_t1_c)
   );

   // Add {q3, q0[3:2]} to t1: low nibble here, carry ripples upward below.
   adder_4bit u_add_t2 (
      .i_a   (w_t1_lo),
      .i_b   ({w_q3[1:0], w_q0[3:2]}),
      .i_cin (1'b0),
      .o_sum (w_t2_lo),
      .o_cout(w_t2_c)
   );

   // Upper two bits of t2: t1[4] + q3[3:2] + carry. The product never
   // exceeds 225, so the carry out of bit 5 is always zero and dropped.
   assign {w_t2_c5, w_t2_b4} = full_add(w_t1_c, w_q3[2], w_t2_c);
   assign w_t2_b5            = w_q3[3] ^ w_t2_c5;

   assign w_product = {w_t2_b5, w_t2_b4, w_t2_lo, w_q0[1:0]};

   // Product register; asynchronous clear isolates the tree from reset timing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
      end else begin
         r_result <= w_product;
      end
   end

   assign Result = r_result;

endmodule

// File: tb/tb_mult_4bit.sv
// Self-checking bench for mult_4bit: scoreboard queue of expected products
// pushed when operands are driven and popped after the capturing edge.
module tb_mult_4bit;

   logic       clk;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic [7:0] Result;

   logic [7:0] exp_q[$];
   int         n_cmp;
   int         n_err;

   mult_4bit dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .Result(Result)
   );

   // Clock: 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 8'h%02h expected 8'h%02h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] wa;
      logic [7:0] wb;
      wa = {4'b0000, a};
      wb = {4'b0000, b};
      return wa * wb;
   endfunction

   // Drive one operand pair on the falling edge, push its expected product,
   // then pop and compare just after the capturing rising edge.
   task automatic drive(input string tag, input logic [3:0] a, input logic [3:0] b);
      logic [7:0] e;
      @(negedge clk);
      A = a;
      B = b;
      exp_q.push_back(model(a, b));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_val({tag, "_queue_empty"}, Result, 8'hxx);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, Result, e);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;

      // Reset with the maximum operands applied.
      rst = 1'b1;
      A   = 4'hF;
      B   = 4'hF;
      #1;
      check_val("reset_immediate", Result, 8'h00);
      repeat (3) begin
         @(posedge clk);
         #1;
         check_val("reset_held", Result, 8'h00);
      end

      // Release: first product appears after the next edge.
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("release_before_edge", Result, 8'h00);
      @(posedge clk);
      #1;
      check_val("release_first", Result, 8'hE1);

      // Corners.
      drive("corner_0x9", 4'd0, 4'd9);
      drive("corner_1x13", 4'd1, 4'd13);
      drive("corner_15x15", 4'd15, 4'd15);

      // Mixed values exercising carries into the upper nibble.
      drive("mixed_5x3", 4'd5, 4'd3);
      drive("mixed_9x12", 4'd9, 4'd12);
      drive("mixed_10x7", 4'd10, 4'd7);

      // Asynchronous reset mid-stream while Result holds 8'h46.
      #2;
      rst = 1'b1;
      #1;
      check_val("async_clear", Result, 8'h00);
      #1;
      rst = 1'b0;
      #1;
      check_val("async_hold_zero", Result, 8'h00);
      drive("resume_5x3", 4'd5, 4'd3);

      // Back-to-back: A advances every 2 cycles, B every cycle.
      for (int i = 0; i < 16; i++) begin
         drive("b2b", 4'(i / 2), 4'(i));
      end

      // Exhaustive sweep, one pair per cycle.
      for (int i = 0; i < 256; i++) begin
         drive("exhaustive", 4'(i >> 4), 4'(i & 15));
      end

      // Random tail.
      repeat (32) begin
         drive("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mult_4bit.md
Name: mult_4bit

Overview:
- Unsigned 4x4-bit Vedic (Urdhva-Tiryagbhyam) multiplier with a registered 8-bit product.
- Leaf arithmetic block of the 64-bit Vedic multiplier hierarchy.
- Built from four 2x2 Vedic multipliers and a partial-product adder tree.
- The result register isolates the combinational tree from downstream logic.

Parameters:
- None. Operand width is fixed at 4 bits and product width at 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  4  unsigned multiplicand
- B  input  4  unsigned multiplier
- Result  output  8  registered unsigned product A*B

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high. While rst=1, Result=8'h00 immediately, independent of clk.
- Latency: A and B are sampled on each rising clk edge with rst=0. Result = A*B at that edge and holds until the next edge. Latency is 1 cycle, throughput is 1 product per cycle, and there is no handshake.
- Arithmetic: all operands are unsigned. The full product always fits in 8 bits; max is 15*15 = 225 = 8'hE1. There is no overflow and no truncation.
- Vedic structure: split A = {Ah, Al} and B = {Bh, Bl}, 2 bits each.
  - q0 = Al*Bl, q1 = Ah*Bl, q2 = Al*Bh, q3 = Ah*Bh. Each is 4 bits, from a 2x2 Vedic cell.
  - Result[1:0] = q0[1:0].
  - t1 = q1 + q2, 5 bits.
  - t2 = t1 + {q3, q0[3:2]}, 6 bits, upper bits zero-extended.
  - Result[7:2] = t2[5:0].
- 2x2 cell:
  - p0 = a0&b0.
  - {c1, p1} = half-add(a1&b0, a0&b1).
  - {p3, p2} = half-add(a1&b1, c1).
- Combinational path: the tree is purely combinational between the inputs and the Result register. No latches and no internal state besides Result.
- Reset release: the first valid Result appears one edge after rst deasserts.
- Reset mid-operation: Result clears immediately. The in-flight product is discarded, not held.
- X handling: inputs are assumed 2-state. With rst=1, Result must be 0 even if A/B are X.

Decomposition:
- Shared package (vedic_pkg):
  - localparam OP_W=4, PROD_W=8;
  - typedef logic [3:0] op4_t;
  - typedef logic [7:0] prod8_t.
- Sub-module: mult_2bit (2x2 Vedic cell built from two half-adders). Instantiate it 4 times.
- Adders: a 4-bit ripple adder instantiated twice (t1; the lower nibble of t2 with carry propagation into the upper bits). It may live in the same file or as adder_4bit.
- The top level holds the adder tree plus one 8-bit register with async reset.

Test Plan:
- Reset: assert rst with A=4'hF, B=4'hF, clock running → Result=8'h00 immediately and throughout reset. On deassert → Result=8'hE1 (225) after the next edge.
- Corners:
  - A=0, B=9 → 8'h00.
  - A=1, B=13 → 8'h0D.
  - A=15, B=15 → 8'hE1.
  - Each appears exactly one edge after being applied.
- Mixed values:
  - A=5, B=3 → 8'h0F.
  - A=9, B=12 → 8'h6C (108).
  - A=10, B=7 → 8'h46 (70).
  - Check the carry chain into bits [7:4].
- Back-to-back: change A/B every cycle (A increments every 2 cycles, B every cycle, starting from 0) → each Result equals the previous cycle's A*B, with no bubbles.
- Reset mid-stream: pulse rst asynchronously between edges while Result=8'h46 → Result drops to 0 without waiting for clk. It resumes correct products one edge after release.
- Exhaustive: all 256 (A,B) pairs, one per cycle → Result == A*B against the scoreboard model, zero mismatches.
